// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: runtime-loaded register table replayed as {DEV_ADDR, word} I2C writes with
// bounded NACK retry, inter-write gap and sticky status. Define I2C_SEQ_ERR_SKIP_EN to skip failed entries.
module i2c_reg_sequencer #(
   parameter logic [7:0] DEV_ADDR    = 8'h34,
   parameter int         DATA_W      = 16,
   parameter int         DEPTH       = 16,
   parameter int         IDX_W       = 4,
   parameter int         MAX_RETRIES = 3,
   parameter int         GAP_CYCLES  = 0,
   parameter int         GAP_W       = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                go,
   input  logic [IDX_W-1:0]    last_index,
   input  logic                cfg_we,
   input  logic [IDX_W-1:0]    cfg_addr,
   input  logic [DATA_W-1:0]   cfg_wdata,
   output logic                i2c_start,
   output logic [8+DATA_W-1:0] i2c_data,
   input  logic                i2c_done,
   input  logic                i2c_ack,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [IDX_W-1:0]    status,
   output logic [IDX_W-1:0]    err_index
);

   localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
   localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;
   localparam logic [2:0] S_ERROR = 3'd6;

   // A zero gap skips the GAP state entirely so back-to-back spacing stays latency + 2.
   localparam logic [2:0] S_NEXT = (GAP_CYCLES == 0) ? S_LOAD : S_GAP;

   logic [2:0]         state;
   logic [DATA_W-1:0]  tbl [DEPTH];
   logic [RETRY_W-1:0] retry_cnt;
   logic [GAP_W-1:0]   gap_cnt;
   logic               wait_armed;

   assign i2c_start = (state == S_START);

   // NOTE: the table is a flop array that reset clears, so a fresh bring-up never replays stale words.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      end else if (cfg_we && !busy) begin
         tbl[cfg_addr] <= cfg_wdata;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         i2c_data   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         status     <= '0;
         err_index  <= '0;
         retry_cnt  <= '0;
         gap_cnt    <= '0;
         wait_armed <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (go) begin
                  status    <= '0;
                  retry_cnt <= '0;
                  done      <= 1'b0;
                  error     <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               i2c_data <= {DEV_ADDR, tbl[status]};
               state    <= S_START;
            end
            S_START: begin
               wait_armed <= 1'b0;
               state      <= S_WAIT;
            end
            S_WAIT: begin
               // The controller's done is ignored in the cycle right after the start pulse.
               if (!wait_armed) begin
                  wait_armed <= 1'b1;
               end else if (i2c_done) begin
                  gap_cnt <= '0;
                  if (i2c_ack) begin
                     if (status == last_index) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                     end else begin
                        status    <= status + 1'b1;
                        retry_cnt <= '0;
                        state     <= S_NEXT;
                     end
                  end else if (retry_cnt < RETRY_MAX) begin
                     retry_cnt <= retry_cnt + 1'b1;
                     state     <= S_NEXT;
                  end else begin
                     err_index <= status;
                     error     <= 1'b1;
`ifdef I2C_SEQ_ERR_SKIP_EN
                     if (status == last_index) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                     end else begin
                        status    <= status + 1'b1;
                        retry_cnt <= '0;
                        state     <= S_NEXT;
                     end
`else
                     busy  <= 1'b0;
                     state <= S_ERROR;
`endif
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) state <= S_LOAD;
               else gap_cnt <= gap_cnt + 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: two sequencers (gap 0 and gap 20) driven by randomized controller models and
// checked against a transfer-list model of the table, retry and skip rules.
module tb_i2c_reg_sequencer;
   localparam int DW        = 16;
   localparam int IW        = 4;
   localparam int MAXR      = 3;
   localparam int GAP0      = 0;
   localparam int GAP1      = 20;
   localparam int RUN_BOUND = 4000;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          go, cfg_we;
   logic [IW-1:0] last_index, cfg_addr;
   logic [DW-1:0] cfg_wdata;
   logic          start_s  [2];
   logic [23:0]   data_s   [2];
   logic          done_in  [2];
   logic          ack_in   [2];
   logic          busy_s   [2];
   logic          done_s   [2];
   logic          error_s  [2];
   logic [IW-1:0] status_s [2];
   logic [IW-1:0] erridx_s [2];

   i2c_reg_sequencer #(.GAP_CYCLES(GAP0)) dut0 (
      .clk(clk), .reset_n(reset_n), .go(go), .last_index(last_index),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .i2c_start(start_s[0]), .i2c_data(data_s[0]), .i2c_done(done_in[0]), .i2c_ack(ack_in[0]),
      .busy(busy_s[0]), .done(done_s[0]), .error(error_s[0]), .status(status_s[0]), .err_index(erridx_s[0]));

   i2c_reg_sequencer #(.GAP_CYCLES(GAP1)) dut1 (
      .clk(clk), .reset_n(reset_n), .go(go), .last_index(last_index),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .i2c_start(start_s[1]), .i2c_data(data_s[1]), .i2c_done(done_in[1]), .i2c_ack(ack_in[1]),
      .busy(busy_s[1]), .done(done_s[1]), .error(error_s[1]), .status(status_s[1]), .err_index(erridx_s[1]));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model: table shadow, per-entry NACK counts, and the expected list of transfers for one run.
   logic [DW-1:0] shadow [16];
   int            nacks  [16];
   logic [23:0]   exp_data [$];
   bit            exp_ack  [$];
   bit            exp_done, exp_err;
   int            exp_status, mdl_erridx;

   int rd [2], cnt [2], lat [2], last_done_cyc [2];
   bit act [2], cur_ack [2], spur [2], have_done [2];

   int          tests = 0;
   int          fails = 0;
   int          n_starts0, cnt_match0, last_gap1;
   bit          first_seen0;
   logic [23:0] first_data0, last_data0, match_word;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // One clock: sample DUT outputs on the falling edge, play the controller, check each start pulse.
   task automatic step();
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         done_in[g] = 1'b0;
         ack_in[g]  = 1'b0;
         if (!reset_n) begin
            act[g]       = 1'b0;
            have_done[g] = 1'b0;
         end else begin
            if (act[g]) begin
               cnt[g]++;
               if (cnt[g] == lat[g]) begin
                  done_in[g]       = 1'b1;
                  ack_in[g]        = cur_ack[g];
                  act[g]           = 1'b0;
                  last_done_cyc[g] = cyc;
                  have_done[g]     = (rd[g] < int'(exp_data.size()));
               end else if (cnt[g] == 1 && spur[g]) begin
                  done_in[g] = 1'b1;
                  ack_in[g]  = ~cur_ack[g];
               end
            end
            if (start_s[g]) begin
               check("busy_during_start", busy_s[g], 1);
               check("start_expected", rd[g] < int'(exp_data.size()), 1);
               if (rd[g] < int'(exp_data.size())) begin
                  check("i2c_data", data_s[g], exp_data[rd[g]]);
                  cur_ack[g] = exp_ack[rd[g]];
                  rd[g]++;
               end else begin
                  cur_ack[g] = 1'b1;
               end
               if (have_done[g]) begin
                  if (g == 1) last_gap1 = cyc - last_done_cyc[g];
                  check("done_to_start", cyc - last_done_cyc[g], ((g == 0) ? GAP0 : GAP1) + 2);
                  have_done[g] = 1'b0;
               end
               if (g == 0) begin
                  n_starts0++;
                  if (!first_seen0) begin
                     first_data0 = data_s[0];
                     first_seen0 = 1'b1;
                  end
                  last_data0 = data_s[0];
                  if (data_s[0] == match_word) cnt_match0++;
               end
               act[g]  = 1'b1;
               cnt[g]  = 0;
               lat[g]  = int'($urandom_range(2, 5));
               spur[g] = (lat[g] > 2) && ($urandom_range(0, 1) == 1);
            end
         end
      end
   endtask

   task automatic build_model(input int last);
      bit ok;
      exp_data.delete();
      exp_ack.delete();
      rd[0] = 0;
      rd[1] = 0;
      exp_err    = 1'b0;
      exp_done   = 1'b1;
      exp_status = last;
      for (int i = 0; i <= last; i++) begin
         ok = 1'b0;
         for (int a = 0; a <= MAXR; a++) begin
            exp_data.push_back({8'h34, shadow[i]});
            exp_ack.push_back(a >= nacks[i]);
            if (a >= nacks[i]) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) begin
            exp_err    = 1'b1;
            mdl_erridx = i;
`ifndef I2C_SEQ_ERR_SKIP_EN
            exp_done   = 1'b0;
            exp_status = i;
            break;
`endif
         end
      end
   endtask

   task automatic write_cfg(input int addr, input logic [DW-1:0] data);
      cfg_we    = 1'b1;
      cfg_addr  = IW'(addr);
      cfg_wdata = data;
      step();
      cfg_we = 1'b0;
      shadow[addr] = data;
   endtask

   function automatic logic [DW-1:0] rnd_word();
      logic [DW-1:0] w;
      do w = DW'($urandom); while (w == 16'h0479 || w == 16'h0555);
      return w;
   endfunction

   task automatic check_zero();
      for (int g = 0; g < 2; g++) begin
         check("rst_start", start_s[g], 0);
         check("rst_data", data_s[g], 0);
         check("rst_busy", busy_s[g], 0);
         check("rst_done", done_s[g], 0);
         check("rst_error", error_s[g], 0);
         check("rst_status", status_s[g], 0);
         check("rst_err_index", erridx_s[g], 0);
      end
   endtask

   // Run one sequence; with poke, pulse go and a table write mid-run (both must be ignored).
   task automatic run_seq(input int last, input bit poke);
      logic [IW-1:0] paddr;
      int k;
      build_model(last);
      n_starts0   = 0;
      cnt_match0  = 0;
      first_seen0 = 1'b0;
      last_index  = IW'(last);
      go = 1'b1;
      step();
      go     = 1'b0;
      cfg_we = 1'b0;
      check("busy_after_go0", busy_s[0], 1);
      check("busy_after_go1", busy_s[1], 1);
      k = 0;
      while ((busy_s[0] || busy_s[1]) && k < RUN_BOUND) begin
         if (poke && k == 10) begin
            go        = 1'b1;
            cfg_we    = 1'b1;
            paddr     = IW'($urandom);
            cfg_addr  = paddr;
            cfg_wdata = ~shadow[paddr];
         end
         step();
         go     = 1'b0;
         cfg_we = 1'b0;
         k++;
      end
      check("run_finished", busy_s[0] | busy_s[1], 0);
      for (int g = 0; g < 2; g++) begin
         check("all_issued", rd[g], exp_data.size());
         check("end_done", done_s[g], exp_done);
         check("end_error", error_s[g], exp_err);
         check("end_status", status_s[g], exp_status);
         check("end_err_index", erridx_s[g], mdl_erridx);
      end
   endtask

   task automatic rand_nacks();
      for (int i = 0; i < 16; i++)
         nacks[i] = ($urandom_range(0, 7) == 0) ? 4 : int'($urandom_range(0, 2));
   endtask

   initial begin
      int k;
      reset_n = 1'b1; go = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; last_index = '0;
      for (int g = 0; g < 2; g++) begin
         done_in[g] = 1'b0; ack_in[g] = 1'b0; act[g] = 1'b0; have_done[g] = 1'b0; rd[g] = 0;
      end
      for (int i = 0; i < 16; i++) begin
         shadow[i] = '0;
         nacks[i]  = 0;
      end
      mdl_erridx = 0;
      match_word = '0;
      last_gap1  = 0;

      #3 reset_n = 1'b0;
      #1 check_zero();
      step(); step();
      reset_n = 1'b1;
      step();

      // All-ACK eleven-entry table.
      write_cfg(0, 16'h0c10);
      for (int i = 1; i < 10; i++) write_cfg(i, rnd_word());
      write_cfg(10, 16'h1201);
      run_seq(10, 1'b0);
      check("lit_first_data", first_data0, 24'h340c10);
      check("lit_last_data", last_data0, 24'h341201);
      check("lit_starts_all_ack", n_starts0, 11);
      check("lit_gap20_spacing", last_gap1, 22);

      // Entry 3 NACKed twice, then ACKed.
      write_cfg(3, 16'h0479);
      nacks[3]   = 2;
      match_word = 24'h340479;
      run_seq(10, 1'b0);
      check("lit_entry3_attempts", cnt_match0, 3);
      check("lit_starts_retry", n_starts0, 13);

      // Entry 5 NACKed forever.
      nacks[3] = 0;
      write_cfg(5, 16'h0555);
      nacks[5]   = 99;
      match_word = 24'h340555;
      run_seq(10, 1'b0);
      check("lit_entry5_attempts", cnt_match0, 4);
      check("lit_err_index5", erridx_s[0], 5);
`ifdef I2C_SEQ_ERR_SKIP_EN
      check("lit_starts_skip", n_starts0, 14);
      check("lit_skip_done", done_s[0], 1);
`else
      check("lit_starts_halt", n_starts0, 9);
      check("lit_halt_status", status_s[0], 5);
`endif

      // Random table; go and a table write while busy must be dropped, then read back.
      for (int i = 0; i < 16; i++) write_cfg(i, rnd_word());
      rand_nacks();
      run_seq(int'($urandom_range(6, 15)), 1'b1);
      rand_nacks();
      run_seq(15, 1'b0);
      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < 3; j++) write_cfg(int'($urandom_range(0, 15)), rnd_word());
         rand_nacks();
         run_seq(int'($urandom_range(0, 15)), 1'b0);
      end

      // Reset during the first WAIT cycle of index 4.
      for (int i = 0; i < 16; i++) nacks[i] = 0;
      build_model(10);
      last_index = 4'd10;
      go = 1'b1;
      step();
      go = 1'b0;
      k = 0;
      while (rd[0] < 5 && k < RUN_BOUND) begin
         step();
         k++;
      end
      check("reached_index4", rd[0], 5);
      step();
      check("busy_before_reset", busy_s[0], 1);
      #2 reset_n = 1'b0;
      #1 check_zero();
      for (int i = 0; i < 16; i++) shadow[i] = '0;
      mdl_erridx = 0;
      exp_data.delete();
      exp_ack.delete();
      step(); step();
      reset_n = 1'b1;
      step();
      run_seq(0, 1'b0);
      check("lit_post_reset_starts", n_starts0, 1);
      check("lit_post_reset_data", first_data0, 24'h340000);

      // Table write and go in the same cycle.
      cfg_we    = 1'b1;
      cfg_addr  = '0;
      cfg_wdata = 16'h1201;
      shadow[0] = 16'h1201;
      run_seq(0, 1'b0);
      check("lit_same_cycle_data", first_data0, 24'h341201);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
- Programmable I2C register-write sequencer for codec/peripheral bring-up; successor to the fixed-table audio codec configurator.
- Holds a DEPTH-entry table of DATA_W-bit register words, loaded at runtime through a host write port. On go, issues {DEV_ADDR, word} writes in order through the existing i2c_controller handshake.
- Adds bounded retry, a programmable inter-write gap, and busy/done/error status with error index.

Parameters:
- DEV_ADDR, 8'h34, 8-bit I2C write address prefixed to every transfer.
- DATA_W, 16, table word width; i2c_data width is 8+DATA_W.
- DEPTH, 16, table entries; must be 2^IDX_W.
- IDX_W, 4, index width.
- MAX_RETRIES, 3, NACK retries per entry before failure (0 = no retry).
- GAP_CYCLES, 0, idle clocks between transfers.
- GAP_W, 16, gap counter width; GAP_CYCLES < 2^GAP_W.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- go  in  1  one-cycle pulse: start sequence from index 0
- last_index  in  IDX_W  final table index of the sequence (inclusive)
- cfg_we  in  1  table write strobe
- cfg_addr  in  IDX_W  table write index
- cfg_wdata  in  DATA_W  table write data
- i2c_start  out  1  one-cycle start pulse to i2c_controller
- i2c_data  out  8+DATA_W  {DEV_ADDR, table word}, stable from LOAD until the next LOAD
- i2c_done  in  1  transfer complete, from controller
- i2c_ack  in  1  all bytes ACKed, qualified by i2c_done
- busy  out  1  sequence in progress
- done  out  1  sequence completed (sticky)
- error  out  1  an entry exhausted its retries (sticky)
- status  out  IDX_W  current table index
- err_index  out  IDX_W  index of the most recent failed entry

Behaviour:
- Reset (async assert, sync release): state IDLE; i2c_start=0, i2c_data=0, busy=0, done=0, error=0, status=0, err_index=0, retry count 0, gap count 0, all table entries 0.
- Reset mid-transfer aborts immediately; the controller is not reset by this block.
- Table: flop array.
  - cfg_we writes table[cfg_addr] on the clock edge, only when busy=0.
  - Writes while busy are dropped.
  - cfg_we and go in the same cycle: the write lands, and the sequence reads the new value.
- States: IDLE, LOAD, START, WAIT, GAP, DONE, ERROR.
- IDLE/DONE/ERROR on go:
  - status<=0, retry<=0, done<=0, error<=0, busy<=1.
  - Next state LOAD.
- go is ignored while busy.
- LOAD (1 cycle): i2c_data<={DEV_ADDR, table[status]}. Next state START.
- START (1 cycle): i2c_start=1. Next state WAIT.
- WAIT:
  - i2c_start=0. i2c_done is not sampled in the first WAIT cycle, one clock after the start pulse; sampled from the second WAIT cycle on. No timeout.
  - done with ack=1 and status==last_index: go to DONE.
  - done with ack=1 otherwise: status++, retry<=0, go to GAP.
  - done with ack=0 and retry<MAX_RETRIES: retry++, go to GAP (same index).
  - done with ack=0 and retry==MAX_RETRIES: err_index<=status, go to ERROR.
- GAP: hold for exactly GAP_CYCLES clocks, then LOAD. GAP_CYCLES=0 means WAIT goes directly to LOAD.
- Start-to-start spacing for back-to-back entries: controller latency + GAP_CYCLES + 2.
- DONE: busy=0, done=1; status holds last_index.
- ERROR: busy=0, error=1; status holds the failing index.
- last_index is sampled continuously and must be held stable while busy. last_index=0 runs a single entry.
- status never wraps: the sequence ends at last_index ≤ DEPTH-1.

Optional Feature:
- Macro I2C_SEQ_ERR_SKIP_EN.
- Defined: retry exhaustion sets error=1 and err_index<=status, then skips the entry.
  - If status==last_index: go to DONE, with both done=1 and error=1.
  - Otherwise: status++, retry<=0, go to GAP.
- Undefined: halt in ERROR as above; done stays 0.

Test Plan:
- Load 11 words (0x0c10…0x1201), last_index=10, GAP_CYCLES=0, controller model always ACKs → 11 start pulses; i2c_data 0x340c10…0x341201 in order; done=1, error=0, status=10.
- Model NACKs entry 3 twice, then ACKs; MAX_RETRIES=3 → entry 3 issued 3 times with identical i2c_data 0x340479; sequence completes with done=1 and error=0.
- Model always NACKs entry 5 → 4 attempts at index 5; error=1, err_index=5, busy=0, no start for index 6. With I2C_SEQ_ERR_SKIP_EN: index 6..10 still issued, then done=1, error=1.
- GAP_CYCLES=20 → measured i2c_done-to-next-i2c_start = 22 clocks. go and cfg_we pulsed while busy → no restart, table unchanged (read back on the next run).
- Assert reset_n=0 during WAIT of index 4 → outputs zero asynchronously, table cleared. A subsequent go with last_index=0 issues exactly one write of 0x340000.
- cfg_we(addr 0, 0x1201) and go in the same cycle → first transfer i2c_data=0x341201.
